scan_ctrl: RTL and testbench
============================

Name: scan_ctrl

Overview:
Sequences the tactile sensor matrix scan. Steps the switch (SW) wire and read (RD) wire selections across every crossing, waits for the analog path to settle, and handshakes one ADC conversion per crossing. Each sample is written into the frame buffer that the display-side address generator reads, at address rd_idx + RD_WIRE_CNT*sw_idx. Supports single-shot and continuous frame scanning.

Parameters:
SW_WIRE_CNT, 16, number of switch (row) wires; must be >= 2.
RD_WIRE_CNT, 16, number of read (column) wires; must be >= 2.
SETTLE_CYCLES, 100, clocks to hold a new selection before starting a conversion; must be >= 1.
ADC_WIDTH, 12, width of ADC sample and frame-buffer word.
TIMEOUT_CYCLES, 1024, clocks to wait for adc_valid_in before declaring a timeout; used only with the optional feature.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  reset; asynchronous, active-low.
start_in  input  1  level; sampled only in IDLE; high starts a frame.
continuous_in  input  1  sampled at end of frame; high restarts at (0,0).
sw_sel_out  output  $clog2(SW_WIRE_CNT)  active switch wire index.
rd_sel_out  output  $clog2(RD_WIRE_CNT)  active read wire index.
sel_valid_out  output  1  high while the mux selection is driven (not IDLE).
adc_start_out  output  1  one-cycle conversion request.
adc_valid_in  input  1  one-cycle pulse; conversion result valid.
adc_data_in  input  ADC_WIDTH  conversion result.
wr_en_out  output  1  one-cycle frame-buffer write strobe.
wr_addr_out  output  $clog2(SW_WIRE_CNT*RD_WIRE_CNT)  frame-buffer write address.
wr_data_out  output  ADC_WIDTH  frame-buffer write data.
frame_done_out  output  1  one-cycle pulse after the last write of a frame.
busy_out  output  1  high in every state except IDLE.
timeout_err_out  output  1  sticky ADC timeout flag.

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE. All outputs 0, including indices, wr_addr_out, wr_data_out, and timeout_err_out. Settle and timeout counters are 0.
- Scan order: rd_idx is the inner loop and sw_idx is the outer loop. (0,0),(0,1)...(0,RD-1),(1,0)...(SW-1,RD-1). Both indices wrap to 0 at frame end.
- IDLE: if start_in=1, next cycle enters SETTLE with sw_sel_out=0, rd_sel_out=0, sel_valid_out=1, busy_out=1, and timeout_err_out cleared.
- SETTLE: selection is held and the counter counts SETTLE_CYCLES clocks in this state. It then moves to CONVERT.
- CONVERT: adc_start_out=1 on the first CONVERT cycle only. The state waits for adc_valid_in and ignores it on the adc_start_out cycle itself. On the first accepted valid, adc_data_in is captured and the state moves to WRITE.
- WRITE: held for exactly 1 cycle.
  - wr_en_out=1.
  - wr_addr_out = rd_idx + RD_WIRE_CNT*sw_idx, computed at full address width with no truncation.
  - wr_data_out = the captured sample.
  - Next state is ADVANCE.
- ADVANCE: held for 1 cycle.
  - If not the last cell: increment rd_idx, or wrap rd_idx to 0 and increment sw_idx. Then go to SETTLE.
  - If last cell: frame_done_out=1 this cycle. If continuous_in=1, indices go to 0 and the state moves to SETTLE; otherwise the state goes to IDLE and sel_valid_out and busy_out drop the next cycle.
- Cell cost without timeout: SETTLE_CYCLES + (CONVERT cycles) + 2.
- start_in outside IDLE: ignored.
- continuous_in: affects only the ADVANCE decision on the last cell. Deasserting it mid-frame finishes the current frame.
- Spurious adc_valid_in outside CONVERT: ignored, with no write.
- wr_data_out and wr_addr_out hold their last values outside WRITE.
- Reset mid-frame: immediate abort. No further writes occur; the next frame starts from (0,0).

Optional Feature:
Macro SCAN_ADC_TIMEOUT_EN.
- Defined:
  - CONVERT counts cycles from entry. If TIMEOUT_CYCLES elapse with no accepted valid, the state moves to WRITE with data = all ones (sentinel), and timeout_err_out is set.
  - timeout_err_out stays set until the next IDLE start or reset. The scan continues normally.
  - A valid arriving on the timeout cycle wins, and no error is flagged.
- Not defined: CONVERT waits indefinitely; timeout_err_out is tied to 0; the TIMEOUT_CYCLES parameter is unused.

Test Plan:
1. SW=RD=4, SETTLE=3, ADC model responds 2 cycles after start with data = 16*sw+rd; pulse start_in, continuous_in=0. Require:
   - exactly 16 writes, with addr 0..15 in order and data matching the model;
   - one frame_done_out pulse;
   - return to IDLE, busy_out=0.
2. Continuous mode with the same setup: after frame_done_out, the next write is addr 0 again. Drop continuous_in mid-frame 2 and require the frame to complete (16 writes) before IDLE.
3. start_in held high through a frame: no restart mid-frame. With continuous_in=0, the next frame starts only from IDLE on the following cycle.
4. Assert rst_in low at cell (2,1): all outputs 0 immediately. After release plus start_in, the first write is addr 0.
5. Inject adc_valid_in during SETTLE and WRITE: no extra wr_en_out pulses. Measure SETTLE length as exactly 3 cycles between the selection change and adc_start_out.
6. With SCAN_ADC_TIMEOUT_EN, TIMEOUT_CYCLES=8, and the ADC silent at cell 5: write addr 5 with data 0xFFF, timeout_err_out=1, and the scan continues to cell 15. Without the macro, the bench stalls in CONVERT and timeout_err_out stays 0.

Source files
------------

// File: rtl/scan_ctrl.sv
// scan_ctrl: tactile sensor matrix scan sequencer.
// Steps (sw, rd) selections row-major with rd as the inner loop. For each
// crossing it settles the analog path, handshakes one ADC conversion and
// writes the sample to the frame buffer at rd + RD_WIRE_CNT*sw.
// Optional build macro: SCAN_ADC_TIMEOUT_EN adds a CONVERT timeout. On timeout
// the sequencer writes an all-ones sentinel and sets a sticky error flag.
module scan_ctrl #(
  parameter int SW_WIRE_CNT    = 16,
  parameter int RD_WIRE_CNT    = 16,
  parameter int SETTLE_CYCLES  = 100,
  parameter int ADC_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SW_W = $clog2(SW_WIRE_CNT),
  localparam int RD_W = $clog2(RD_WIRE_CNT),
  localparam int AW   = $clog2(SW_WIRE_CNT*RD_WIRE_CNT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 continuous_in,
  output logic [SW_W-1:0]      sw_sel_out,
  output logic [RD_W-1:0]      rd_sel_out,
  output logic                 sel_valid_out,
  output logic                 adc_start_out,
  input  logic                 adc_valid_in,
  input  logic [ADC_WIDTH-1:0] adc_data_in,
  output logic                 wr_en_out,
  output logic [AW-1:0]        wr_addr_out,
  output logic [ADC_WIDTH-1:0] wr_data_out,
  output logic                 frame_done_out,
  output logic                 busy_out,
  output logic                 timeout_err_out
);

  // One counter serves both SETTLE and CONVERT, so it is sized for the larger.
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [SW_W-1:0] SW_LAST = SW_W'(SW_WIRE_CNT - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(RD_WIRE_CNT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CONVERT = 3'd2,
    WRITE   = 3'd3,
    ADVANCE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [SW_W-1:0]      sw_q, sw_d;
  logic [RD_W-1:0]      rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 conv_first_q, conv_first_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [ADC_WIDTH-1:0] data_q, data_d;
`ifdef SCAN_ADC_TIMEOUT_EN
  logic                 err_q, err_d;
`endif

  logic          last_cell;
  logic [AW-1:0] cell_addr;

  assign last_cell = (sw_q == SW_LAST) && (rd_q == RD_LAST);
  // Full address width on every operand so the product cannot truncate.
  assign cell_addr = AW'(rd_q) + AW'(RD_WIRE_CNT) * AW'(sw_q);

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      sw_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      conv_first_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
`ifdef SCAN_ADC_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sw_q         <= sw_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      conv_first_q <= conv_first_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
`ifdef SCAN_ADC_TIMEOUT_EN
      err_q        <= err_d;
`endif
    end
  end

  // Next-state logic: settle, convert, write, then advance to the next cell.
  always_comb begin
    state_d      = state_q;
    sw_d         = sw_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    conv_first_d = conv_first_q;
    addr_d       = addr_q;
    data_d       = data_q;
`ifdef SCAN_ADC_TIMEOUT_EN
    err_d        = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = SETTLE;
          sw_d    = '0;
          rd_d    = '0;
          cnt_d   = '0;
`ifdef SCAN_ADC_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d      = CONVERT;
          cnt_d        = '0;
          conv_first_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONVERT: begin
        conv_first_d = 1'b0;
        // A valid pulse on the request cycle belongs to no conversion of ours.
        if (!conv_first_q && adc_valid_in) begin
          state_d = WRITE;
          data_d  = adc_data_in;
          addr_d  = cell_addr;
          cnt_d   = '0;
        end
`ifdef SCAN_ADC_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = WRITE;
          data_d  = '1;
          addr_d  = cell_addr;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WRITE: begin
        state_d = ADVANCE;
      end
      ADVANCE: begin
        cnt_d = '0;
        if (last_cell) begin
          sw_d    = '0;
          rd_d    = '0;
          state_d = continuous_in ? SETTLE : IDLE;
        end else begin
          state_d = SETTLE;
          if (rd_q == RD_LAST) begin
            rd_d = '0;
            sw_d = sw_q + 1'b1;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sw_sel_out     = sw_q;
  assign rd_sel_out     = rd_q;
  assign sel_valid_out  = (state_q != IDLE);
  assign busy_out       = (state_q != IDLE);
  assign adc_start_out  = (state_q == CONVERT) && conv_first_q;
  assign wr_en_out      = (state_q == WRITE);
  assign wr_addr_out    = addr_q;
  assign wr_data_out    = data_q;
  assign frame_done_out = (state_q == ADVANCE) && last_cell;
`ifdef SCAN_ADC_TIMEOUT_EN
  assign timeout_err_out = err_q;
`else
  assign timeout_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl on a 4x4 matrix with SETTLE_CYCLES=3.
// ADC model: answers 2 cycles after each request with data 16*sw+rd.
module tb_scan_ctrl;
  localparam int SW = 4, RD = 4, ST = 3, AD = 12, TO = 8;

  logic        clk_in = 1'b0, rst_in = 1'b0, start_in = 1'b0, continuous_in = 1'b0;
  logic [1:0]  sw_sel_out, rd_sel_out;
  logic        sel_valid_out, adc_start_out, adc_valid_in, wr_en_out;
  logic        frame_done_out, busy_out, timeout_err_out;
  logic [11:0] adc_data_in, wr_data_out;
  logic [3:0]  wr_addr_out;

  scan_ctrl #(.SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .SETTLE_CYCLES(ST),
              .ADC_WIDTH(AD), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .continuous_in(continuous_in),
    .sw_sel_out(sw_sel_out), .rd_sel_out(rd_sel_out), .sel_valid_out(sel_valid_out),
    .adc_start_out(adc_start_out), .adc_valid_in(adc_valid_in), .adc_data_in(adc_data_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .frame_done_out(frame_done_out), .busy_out(busy_out), .timeout_err_out(timeout_err_out));

  always #5 clk_in = ~clk_in;

  // ADC model plus a separate injector for spurious valid pulses.
  logic        m_vld = 1'b0, inj_vld = 1'b0, p0 = 1'b0, p1 = 1'b0;
  logic [11:0] m_data = '0, d0 = '0, d1 = '0;
  int          silent_cell = -1;
  assign adc_valid_in = m_vld | inj_vld;
  assign adc_data_in  = m_vld ? m_data : (inj_vld ? 12'hABC : 12'h000);

  always @(negedge clk_in) begin
    if (!rst_in) begin
      p0 <= 1'b0; p1 <= 1'b0; m_vld <= 1'b0;
    end else begin
      m_vld  <= p1;
      m_data <= d1;
      p1     <= p0;
      d1     <= d0;
      p0     <= adc_start_out && ((int'(sw_sel_out) * 4 + int'(rd_sel_out)) != silent_cell);
      d0     <= 12'(16 * int'(sw_sel_out) + int'(rd_sel_out));
    end
  end

  // Write / frame_done monitor.
  logic [3:0]  wa_q[$];
  logic [11:0] wd_q[$];
  int          fd_cnt = 0;
  always @(negedge clk_in) begin
    if (wr_en_out) begin
      wa_q.push_back(wr_addr_out);
      wd_q.push_back(wr_data_out);
    end
    if (frame_done_out) fd_cnt <= fd_cnt + 1;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " ctl"}, int'({sw_sel_out, rd_sel_out, sel_valid_out, busy_out, adc_start_out,
                            wr_en_out, frame_done_out, timeout_err_out}), 0);
    chk({nm, " addr"}, int'(wr_addr_out), 0);
    chk({nm, " data"}, int'(wr_data_out), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk_in) start_in = 1'b1;
    @(negedge clk_in) start_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    @(negedge clk_in);
    while (busy_out && n < budget) begin @(negedge clk_in); n++; end
    chk(nm, int'(busy_out), 0);
  endtask

  task automatic wait_fd(input int budget, input string nm);
    int n = 0;
    while (!frame_done_out && n < budget) begin @(negedge clk_in); n++; end
    chk(nm, int'(frame_done_out), 1);
  endtask

  function automatic int wa(input int i);
    return (i < wa_q.size()) ? int'(wa_q[i]) : -1;
  endfunction
  function automatic int wd(input int i);
    return (i < wd_q.size()) ? int'(wd_q[i]) : -1;
  endfunction

  typedef struct {
    int sw;
    int rd;
    int exp_addr;
    int exp_data;
  } vec_t;

  initial begin
    vec_t tbl[16];
    int base, f0, n;
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 4; r++)
        tbl[s*4 + r] = '{s, r, s*4 + r, 16*s + r};

    // Reset state
    repeat (3) @(negedge clk_in);
    chk_zero("reset");
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("idle busy", int'(busy_out), 0);

    // 1: single frame, table-driven write check
    base = wa_q.size(); f0 = fd_cnt;
    pulse_start();
    wait_idle(300, "t1 idle");
    #1;
    chk("t1 writes", wa_q.size() - base, 16);
    chk("t1 frame_done", fd_cnt - f0, 1);
    chk("t1 sel_valid", int'(sel_valid_out), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1 addr (%0d,%0d)", tbl[i].sw, tbl[i].rd), wa(base + i), tbl[i].exp_addr);
      chk($sformatf("t1 data (%0d,%0d)", tbl[i].sw, tbl[i].rd), wd(base + i), tbl[i].exp_data);
    end

    // 2: continuous, drop continuous_in mid frame 2
    base = wa_q.size(); f0 = fd_cnt;
    continuous_in = 1'b1;
    pulse_start();
    wait_fd(300, "t2 fd1");
    n = 0;
    while (wa_q.size() < base + 21 && n < 200) begin @(negedge clk_in); n++; end
    continuous_in = 1'b0;
    wait_idle(300, "t2 idle");
    #1;
    chk("t2 writes", wa_q.size() - base, 32);
    chk("t2 frame_done", fd_cnt - f0, 2);
    chk("t2 restart addr", wa(base + 16), 0);
    chk("t2 last addr", wa(base + 31), 15);
    chk("t2 last data", wd(base + 31), 51);

    // 3: start_in held high across the frame
    base = wa_q.size();
    @(negedge clk_in) start_in = 1'b1;
    wait_fd(300, "t3 fd");
    chk("t3 writes f1", wa_q.size() - base, 16);
    chk("t3 last addr f1", wa(base + 15), 15);
    @(negedge clk_in);
    chk("t3 idle gap", int'(busy_out), 0);
    @(negedge clk_in);
    chk("t3 restart busy", int'(busy_out), 1);
    chk("t3 restart sel", int'({sw_sel_out, rd_sel_out}), 0);
    start_in = 1'b0;
    wait_idle(300, "t3 idle");
    #1;
    chk("t3 writes total", wa_q.size() - base, 32);

    // 4: reset at cell (2,1)
    base = wa_q.size();
    pulse_start();
    n = 0;
    while (!(sw_sel_out == 2'd2 && rd_sel_out == 2'd1) && n < 200) begin @(negedge clk_in); n++; end
    chk("t4 cell", int'({sw_sel_out, rd_sel_out}), 9);
    chk("t4 writes before", wa_q.size() - base, 9);
    rst_in = 1'b0;
    #1;
    chk_zero("t4 reset");
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (10) @(negedge clk_in);
    #1;
    chk("t4 no writes", wa_q.size() - base, 9);
    pulse_start();
    n = 0;
    while (!wr_en_out && n < 50) begin @(negedge clk_in); n++; end
    chk("t4 wr seen", int'(wr_en_out), 1);
    chk("t4 first addr", int'(wr_addr_out), 0);
    wait_idle(300, "t4 idle");

    // 5: spurious valids and settle length
    base = wa_q.size();
    pulse_start();
    inj_vld = 1'b1;
    @(negedge clk_in) inj_vld = 1'b0;
    n = 1;
    while (!adc_start_out && n < 20) begin @(negedge clk_in); n++; end
    chk("t5 settle cell0", n, 3);
    n = 0;
    while (!wr_en_out && n < 20) begin @(negedge clk_in); n++; end
    chk("t5 wr data cell0", int'(wr_data_out), 0);
    inj_vld = 1'b1;
    @(negedge clk_in) inj_vld = 1'b0;
    chk("t5 no extra wr", int'(wr_en_out), 0);
    chk("t5 addr hold", int'(wr_addr_out), 0);
    chk("t5 data hold", int'(wr_data_out), 0);
    n = 0;
    while (rd_sel_out != 2'd1 && n < 20) begin @(negedge clk_in); n++; end
    n = 0;
    while (!adc_start_out && n < 20) begin @(negedge clk_in); n++; end
    chk("t5 settle cell1", n, 3);
    wait_idle(300, "t5 idle");
    inj_vld = 1'b1;
    @(negedge clk_in) inj_vld = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    chk("t5 writes", wa_q.size() - base, 16);
    chk("t5 data0", wd(base), 0);
    chk("t5 data1", wd(base + 1), 1);

    // 6: ADC silent at cell 5
    base = wa_q.size();
    silent_cell = 5;
`ifdef SCAN_ADC_TIMEOUT_EN
    pulse_start();
    wait_idle(400, "t6 idle");
    #1;
    chk("t6 writes", wa_q.size() - base, 16);
    chk("t6 addr5", wa(base + 5), 5);
    chk("t6 data5", wd(base + 5), 4095);
    chk("t6 data6", wd(base + 6), 18);
    chk("t6 addr15", wa(base + 15), 15);
    chk("t6 err", int'(timeout_err_out), 1);
    silent_cell = -1;
    pulse_start();
    chk("t6 err cleared", int'(timeout_err_out), 0);
    wait_idle(300, "t6 idle2");
`else
    pulse_start();
    repeat (150) @(negedge clk_in);
    #1;
    chk("t6 stall writes", wa_q.size() - base, 5);
    chk("t6 stall busy", int'(busy_out), 1);
    chk("t6 err", int'(timeout_err_out), 0);
    @(negedge clk_in) rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    silent_cell = -1;
    @(negedge clk_in);
    chk("t6 after reset busy", int'(busy_out), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
